// File: rtl/hybrid_adder.sv
// rtl/hybrid_adder.sv - registered hybrid carry-lookahead/ripple adder (optional carry-in via HYBRID_ADDER_CIN_EN)

// 4-bit group: every carry inside the group is computed in lookahead form from cgin.
module hybrid_adder_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cgin,
   output logic [3:0] s,
   output logic       cgout
);

   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;
   logic       grp_g;
   logic       grp_p;

   // Bit propagate/generate, flat two-level carries, group G/P and sum bits
   always_comb begin
      p     = a ^ b;
      g     = a & b;
      c[0]  = cgin;
      c[1]  = g[0] | (p[0] & cgin);
      c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cgin);
      c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cgin);
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;
      cgout = grp_g | (grp_p & cgin);
      s     = p ^ c;
   end

endmodule

// Top: WIDTH/4 lookahead groups with the group carries rippling, result registered.
module hybrid_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef HYBRID_ADDER_CIN_EN
   input  logic             cin,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
);

   localparam int NGROUPS = WIDTH / 4;

   if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
      $error("hybrid_adder: WIDTH must be 8, 16, 32 or 64");
   end

   logic [NGROUPS:0] gc;
   logic [WIDTH-1:0] raw_sum;

   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_d;
   logic             cout_q;
   logic             out_valid_d;
   logic             out_valid_q;

`ifdef HYBRID_ADDER_CIN_EN
   assign gc[0] = cin;
`else
   assign gc[0] = 1'b0;
`endif

   for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_grp
      hybrid_adder_cla4 u_grp (
         .a     (a[4*gi +: 4]),
         .b     (b[4*gi +: 4]),
         .cgin  (gc[gi]),
         .s     (raw_sum[4*gi +: 4]),
         .cgout (gc[gi+1])
      );
   end

   // Load a new result on a valid sample, otherwise hold the last one
   always_comb begin
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         sum_d       = raw_sum;
         cout_d      = gc[NGROUPS];
         out_valid_d = 1'b1;
      end
   end

   // Result registers; reset discards any transaction presented with it
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hybrid_adder.sv
// tb/tb_hybrid_adder.sv - bench for hybrid_adder at WIDTH 16/32/64 against an arithmetic model
module tb_hybrid_adder;

`ifdef HYBRID_ADDER_CIN_EN
   localparam bit CIN_EN = 1'b1;
`else
   localparam bit CIN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        cin_tb;
   logic [15:0] a16, b16, sum16;
   logic [31:0] a32, b32, sum32;
   logic [63:0] a64, b64, sum64;
   logic        cout16, cout32, cout64;
   logic        ov16, ov32, ov64;

   logic [15:0] e_sum16;
   logic [31:0] e_sum32;
   logic [63:0] e_sum64;
   logic        e_cout16, e_cout32, e_cout64, e_ov;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hybrid_adder #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16),
`ifdef HYBRID_ADDER_CIN_EN
      .cin(cin_tb),
`endif
      .sum(sum16), .cout(cout16), .out_valid(ov16));

   hybrid_adder #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a32), .b(b32),
`ifdef HYBRID_ADDER_CIN_EN
      .cin(cin_tb),
`endif
      .sum(sum32), .cout(cout32), .out_valid(ov32));

   hybrid_adder #(.WIDTH(64)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a64), .b(b64),
`ifdef HYBRID_ADDER_CIN_EN
      .cin(cin_tb),
`endif
      .sum(sum64), .cout(cout64), .out_valid(ov64));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the model by the same edge, compare every DUT.
   task automatic cycle(input logic r, input logic iv, input logic c,
                        input logic [15:0] x16, input logic [15:0] y16,
                        input logic [31:0] x32, input logic [31:0] y32,
                        input logic [63:0] x64, input logic [63:0] y64);
      logic [16:0] r16;
      logic [32:0] r32;
      logic [64:0] r64;
      logic        ce;
      @(negedge clk);
      rst = r; in_valid = iv; cin_tb = c;
      a16 = x16; b16 = y16; a32 = x32; b32 = y32; a64 = x64; b64 = y64;
      ce  = CIN_EN & c;
      r16 = 17'(x16) + 17'(y16) + 17'(ce);
      r32 = 33'(x32) + 33'(y32) + 33'(ce);
      r64 = 65'(x64) + 65'(y64) + 65'(ce);
      @(posedge clk);
      #1;
      if (r) begin
         e_sum16 = '0; e_sum32 = '0; e_sum64 = '0;
         e_cout16 = 0; e_cout32 = 0; e_cout64 = 0; e_ov = 0;
      end else if (iv) begin
         {e_cout16, e_sum16} = r16;
         {e_cout32, e_sum32} = r32;
         {e_cout64, e_sum64} = r64;
         e_ov = 1'b1;
      end else begin
         e_ov = 1'b0;
      end
      check("sum16",  64'(sum16),  64'(e_sum16));
      check("cout16", 64'(cout16), 64'(e_cout16));
      check("ov16",   64'(ov16),   64'(e_ov));
      check("sum32",  64'(sum32),  64'(e_sum32));
      check("cout32", 64'(cout32), 64'(e_cout32));
      check("ov32",   64'(ov32),   64'(e_ov));
      check("sum64",  sum64,       e_sum64);
      check("cout64", 64'(cout64), 64'(e_cout64));
      check("ov64",   64'(ov64),   64'(e_ov));
   endtask

   function automatic logic [63:0] pick64();
      case ($urandom_range(0, 5))
         0:       return '1;
         1:       return '0;
         2:       return 64'h8000_0000_0000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [63:0] x, y;
      rst = 1; in_valid = 0; cin_tb = 0;
      a16 = '0; b16 = '0; a32 = '0; b32 = '0; a64 = '0; b64 = '0;

      // reset state
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_sum16", 64'(sum16), 64'h0);
      check("rst_ov16",  64'(ov16),  64'h0);

      // partial carry chain (16), multi-group (32), full ripple (64)
      cycle(0, 1, 0, 16'hFA38, 16'h00F1, 32'hFA38FFFF, 32'h00F2AA51,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
      check("t1_sum16", 64'(sum16), 64'hFB29);
      check("t1_cout16", 64'(cout16), 64'h0);
      check("t3_sum32", 64'(sum32), 64'hFB2BAA50);
      check("t3_cout32", 64'(cout32), 64'h0);
      check("t4_sum64", sum64, 64'h0);
      check("t4_cout64", 64'(cout64), 64'h1);

      // carry out (16), back-to-back MSB-only carry (64)
      cycle(0, 1, 0, 16'hFC42, 16'hBF10, 32'h1, 32'h2,
            64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      check("t2_sum16", 64'(sum16), 64'hBB52);
      check("t2_cout16", 64'(cout16), 64'h1);
      check("t4b_sum64", sum64, 64'h0);
      check("t4b_cout64", 64'(cout64), 64'h1);

      // idle cycle holds values and drops valid
      cycle(0, 0, 0, 16'h5555, 16'h5555, 0, 0, 0, 0);
      check("hold_sum16", 64'(sum16), 64'hBB52);
      check("hold_cout16", 64'(cout16), 64'h1);
      check("hold_ov16", 64'(ov16), 64'h0);

      // carry-in
      cycle(0, 1, 1, 16'hFFFF, 16'h0000, 32'hFFFF_FFFF, 32'h0, 64'h0, 64'h0);
      if (CIN_EN) begin
         check("t5_sum16", 64'(sum16), 64'h0000);
         check("t5_cout16", 64'(cout16), 64'h1);
      end else begin
         check("t5_sum16", 64'(sum16), 64'hFFFF);
         check("t5_cout16", 64'(cout16), 64'h0);
      end

      // reset with a transaction in the same cycle discards it
      cycle(1, 1, 0, 16'h1234, 16'h1111, 32'h1234, 32'h1111, 64'h1234, 64'h1111);
      check("t6_rst_sum16", 64'(sum16), 64'h0);
      check("t6_rst_ov16", 64'(ov16), 64'h0);
      cycle(0, 1, 0, 16'h1234, 16'h1111, 32'h1234, 32'h1111, 64'h1234, 64'h1111);
      check("t6_sum16", 64'(sum16), 64'h2345);
      check("t6_cout16", 64'(cout16), 64'h0);
      check("t6_ov16", 64'(ov16), 64'h1);

      // randomized traffic with occasional idle and reset cycles
      for (int i = 0; i < 300; i++) begin
         x = pick64();
         y = pick64();
         cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
               1'($urandom), x[15:0], y[15:0], x[31:0], y[31:0], x, y);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hybrid_adder.md
# hybrid_adder

Registered, width-parameterised unsigned adder built as a hybrid of carry-lookahead and ripple-carry. Each 4-bit group computes its carries with lookahead logic, and the group carry-out ripples to the next group. It serves as the shared datapath adder for 16/32/64-bit instances and adds two operands with a one-cycle registered result.

## Interface

**Parameters**
- `WIDTH`, default 16: operand/sum width. Legal values are 8, 16, 32 and 64, so it is always a multiple of 4. Any other value is a compile-time error.

**Ports**
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: `a`/`b` (and `cin`) are sampled on this edge.
- `a`, input, WIDTH: operand A, unsigned.
- `b`, input, WIDTH: operand B, unsigned.
- `cin`, input, 1: carry-in. Present only with `HYBRID_ADDER_CIN_EN`.
- `sum`, output, WIDTH: registered `(a + b + cin) mod 2^WIDTH`.
- `cout`, output, 1: registered carry out of bit WIDTH-1.
- `out_valid`, output, 1: `sum`/`cout` hold a result issued one cycle earlier.

## Operation

- **Group structure:** the datapath is split into WIDTH/4 groups of 4 bits.
  - Per group and bit i: `p = a^b`, `g = a&b`.
  - Carries inside a group are computed in lookahead form from the group carry-in, e.g. `c1 = g0 | p0&cgin`, `c2 = g1 | p1&g0 | p1&p0&cgin`, and so on; there is no ripple inside a group.
  - Group carry-out: `G | P&cgin`, with `G` and `P` as the group generate/propagate.
  - Group carry-outs ripple group to group. Group 0 carry-in is `cin`, or 0 when the macro is off.
  - Sum bit: `s_i = p_i ^ c_i`.
- **Result:** `{cout,sum}` equals the WIDTH+1-bit exact sum of `a + b + cin`. No saturation, no signed interpretation and no overflow flag.
- **Registers:**
  - On a rising edge with `rst=0` and `in_valid=1`: `sum`/`cout` load the new result and `out_valid` becomes 1.
  - With `rst=0` and `in_valid=0`: `sum`/`cout` hold their previous values and `out_valid` becomes 0.
- **Reset:** on a rising edge with `rst=1`, `sum=0`, `cout=0` and `out_valid=0`, regardless of `in_valid`. A transaction presented in the same cycle as reset is discarded.
- **Back-to-back operation:** there is no backpressure. `in_valid` may be high every cycle, and each cycle's result appears exactly one cycle later.

## Timing

- Latency is 1 clock from the sampling edge to the result on `sum`/`cout`/`out_valid`. Throughput is 1 result per clock.
- Outputs are driven only by flops; no combinational path runs from inputs to outputs.
- The critical path is the group-carry ripple, roughly WIDTH/4 group delays plus one 4-bit lookahead, and must close at the target clock for WIDTH=64.
- After `rst` deasserts, the first valid result appears on the edge following the first `in_valid=1` sample.
- Reset asserted mid-stream clears `out_valid` on that edge; the cycle after reset deasserts carries no stale result.

## Configuration

- **`HYBRID_ADDER_CIN_EN` defined:**
  - The `cin` input port exists and feeds the group-0 carry-in.
  - `cin` is sampled together with `a`/`b` when `in_valid=1`.
- **`HYBRID_ADDER_CIN_EN` undefined:**
  - There is no `cin` port and the group-0 carry-in is constant 0.
  - The result is `a + b` only.

## Test plan

1. **Partial carry chain, WIDTH=16:** `a=0xFA38`, `b=0x00F1`, `in_valid=1` -> next cycle `sum=0xFB29`, `cout=0`, `out_valid=1`.
2. **Carry out, WIDTH=16:** `a=0xFC42`, `b=0xBF10` -> `sum=0xBB52`, `cout=1`. Then `in_valid=0` for one cycle -> values hold and `out_valid=0`.
3. **Multi-group carries, WIDTH=32:** `a=0xFA38FFFF`, `b=0x00F2AA51` -> `sum=0xFB2BAA50`, `cout=0`.
4. **Full ripple across all 16 groups, WIDTH=64:** `a=0xFFFF_FFFF_FFFF_FFFF`, `b=0x1` -> `sum=0`, `cout=1`. Then back-to-back `a=b=0x8000_0000_0000_0000` on the next cycle -> `sum=0`, `cout=1` one cycle later.
5. **Carry-in, WIDTH=16, `HYBRID_ADDER_CIN_EN` defined:** `a=0xFFFF`, `b=0x0000`, `cin=1` -> `sum=0x0000`, `cout=1`. With the macro undefined, the same `a`/`b` give `sum=0xFFFF`, `cout=0`.
6. **Reset:** assert `rst` in the same cycle as `in_valid=1`, `a=0x1234`, `b=0x1111` -> next edge `sum=0`, `cout=0`, `out_valid=0`. After deassert, `a=0x1234`, `b=0x1111` -> `sum=0x2345`, `cout=0`.
